// File: rtl/uart_loopback_pkg.sv
// Shared types for the UART loopback FIFO.
// Tx FSM encoding and runtime mode codes.
package uart_loopback_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    VALID = 2'd2
  } tx_state_e;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data,
// occupancy count and single-cycle flush.
module sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_rdata,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en, rd_en;

  assign o_full  = (cnt_q == CNT_W'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;
  assign o_rdata = rdata_q;

  assign wr_en = i_wr & ~o_full & ~i_flush;
  assign rd_en = i_rd & ~o_empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (i_flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + 1'b1;
      if (rd_en) rptr_d = rptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wptr_q] <= i_wdata;
  end

  // Read data is captured even under flush so an in-flight pop completes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (rd_en) rdata_q <= mem_q[rptr_q];
    end
  end

endmodule

// File: rtl/uart_loopback_fifo.sv
// UART rx->tx loopback through a FIFO with pass,
// invert and hold modes, flush and overflow status.
module uart_loopback_fifo
  import uart_loopback_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_byte_rdy,
  input  logic [DATA_W-1:0] i_rx_byte,
  output logic              o_tx_byte_rdy,
  output logic [DATA_W-1:0] o_tx_byte,
  input  logic              i_tx_ready,
  input  logic [1:0]        i_mode,
  input  logic              i_flush,
  input  logic              i_ovf_clr,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rdata;
  logic              rdy_q;
  logic              ovf_q, ovf_d;
  logic              wr_req, rd, hold;

  assign wr_req = i_rx_byte_rdy & ~rdy_q;
  assign hold   = (i_mode == MODE_HOLD);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wr    (wr_req),
    .i_wdata (i_rx_byte),
    .i_rd    (rd),
    .i_flush (i_flush),
    .o_rdata (rdata),
    .o_count (o_count),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  // Overflow set takes priority over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_req & o_full & ~i_flush) ovf_d = 1'b1;
    else if (i_ovf_clr)             ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!o_empty && !hold) begin
          rd      = 1'b1;
          state_d = PRIME;
        end
      end
      PRIME: begin
        tx_d    = (i_mode == MODE_INV) ? ~rdata : rdata;
        state_d = VALID;
      end
      VALID: begin
        if (i_tx_ready) begin
          if (!o_empty && !hold) begin
            rd      = 1'b1;
            state_d = PRIME;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rdy_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rdy_q   <= i_rx_byte_rdy;
      ovf_q   <= ovf_d;
    end
  end

  assign o_tx_byte_rdy = (state_q == VALID);
  assign o_tx_byte     = tx_q;
  assign o_overflow    = ovf_q;

endmodule

// File: doc/uart_loopback_fifo.md
Name: uart_loopback_fifo

Overview:
Parametrised successor to the single-byte UART loopback. Captures bytes from the UART receiver on the rising edge of its ready flag and queues them in a synchronous FIFO. Drains the FIFO to the UART transmitter over a valid/ready handshake. Adds runtime modes (pass, invert, hold), flush, occupancy and sticky-overflow status; sits between the uart_rx and uart_tx instances at top level.

Parameters:
DATA_W, 8, byte width on both sides.
DEPTH, 16, FIFO entries; power of two, >= 2.
CNT_W, $clog2(DEPTH)+1, localparam; width of occupancy count.

Ports:
i_clk  in  1  system clock; all logic on rising edge.
i_rst_n  in  1  reset; asynchronous, active-low.
i_rx_byte_rdy  in  1  receiver data-ready level; a byte is taken on its 0->1 transition only.
i_rx_byte  in  DATA_W  received byte; stable while i_rx_byte_rdy high.
o_tx_byte_rdy  out  1  tx valid; held until accepted.
o_tx_byte  out  DATA_W  byte presented to transmitter.
i_tx_ready  in  1  transmitter can accept; transfer on cycle where o_tx_byte_rdy and i_tx_ready are both 1.
i_mode  in  2  00 pass, 01 invert (~byte), 10 hold (no new drains), 11 reserved = pass.
i_flush  in  1  one-cycle pulse; empties FIFO.
i_ovf_clr  in  1  clears o_overflow.
o_count  out  CNT_W  current FIFO occupancy, 0..DEPTH.
o_full  out  1  o_count == DEPTH.
o_empty  out  1  o_count == 0.
o_overflow  out  1  sticky: byte arrived while full.

Behaviour:
- Reset (async assert, sync-released use): o_tx_byte_rdy=0, o_tx_byte=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, pointers 0, rdy-edge register=0, FSM=IDLE.
- Rx capture: registered copy of i_rx_byte_rdy; write request = i_rx_byte_rdy & ~prev. Level held high for many cycles = one byte. High out of reset counts as an edge on the first cycle after release.
- Write accepted iff not full at that edge (pop on the same cycle does not free space for the write). Rejected write sets o_overflow; byte dropped.
- o_overflow: set wins over i_ovf_clr in the same cycle.
- Pointers wrap modulo DEPTH; count tracks write/read: +1, -1, or unchanged on simultaneous write and read.
- Tx FSM: IDLE -> PRIME when FIFO non-empty and i_mode != 10 (issues read; memory read registered). PRIME -> VALID: load o_tx_byte from read data (inverted if i_mode==01, mode sampled this cycle), o_tx_byte_rdy=1. VALID: hold byte and valid until i_tx_ready; on transfer go to PRIME if non-empty and not hold, else IDLE.
- Latency: write at edge E0 -> o_tx_byte_rdy high after E2 (2 cycles). Back-to-back throughput: one byte per 2 cycles.
- Valid never drops or changes byte before transfer, including on mode change, hold, or flush.
- Flush: pointers and count to 0 on next edge; overrides a same-cycle write (write discarded, no overflow). A byte already in VALID is kept; a read in PRIME completes and presents that byte.
- Hold: FIFO still fills; draining resumes from IDLE when mode leaves 10.
- o_full/o_empty combinational from count.

Decomposition:
- Package uart_loopback_pkg: tx FSM state enum (IDLE, PRIME, VALID), mode constants MODE_PASS/MODE_INV/MODE_HOLD.
- Sub-module sync_fifo (DATA_W, DEPTH): storage, pointers, count, full/empty, flush, registered read; top keeps edge detect, overflow, mode, tx FSM.

Test Plan:
- Reset, mode 00, rdy pulses with 0x41,0x42,0x43, i_tx_ready=1 -> tx emits 0x41,0x42,0x43 in order, first valid 2 cycles after first write edge, o_count back to 0.
- i_rx_byte_rdy held high 10 cycles with 0x55 -> exactly one 0x55 transmitted, o_count peak 1.
- i_tx_ready=0, DEPTH+1 bytes 0x00..0x10 -> o_full=1, o_count=16, o_overflow=1, 0x10 dropped; release ready -> 0x00..0x0F out; i_ovf_clr -> o_overflow=0.
- Mode 01, byte 0x3C -> o_tx_byte=0xC3; mode 10 with 3 bytes -> no valid, o_count=3; back to 00 -> all 3 drain.
- i_tx_ready=0, 4 bytes queued, first in VALID, i_flush -> o_count=0, first byte stays valid, transfers once ready=1, then idle.
- Assert i_rst_n=0 mid-transfer (VALID, count=5) -> outputs to reset values immediately without clock edge.
